// File: rtl/noc_relay_station_array_pkg.sv
// Shared types, defaults and elaboration helpers for the NoC relay station array.
package noc_relay_station_array_pkg;

  localparam int DefaultWidth       = 66;
  localparam int DefaultNumPorts    = 5;
  localparam int DefaultStopLatency = 1;
  localparam int DefaultRelayDepth  = 4;

  // Flit at the default link width (preamble included).
  typedef logic [DefaultWidth-1:0] flit_t;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Pointer width, kept at least one bit so a single-entry FIFO still has a pointer.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/noc_relay_station_array_if.sv
// Bundle of all per-channel link signals of the relay station array.
//
// Link protocol (void/stop): a flit is offered on channel i when data_void_*[i]==0.
// The receiver asserts stop[i] to ask the sender to cease offering; the sender may
// keep offering for up to StopLatency cycles afterwards, and the receiver must have
// room for those flits. A flit transfers on every cycle its void bit is 0 and the
// receiver accepts it (downstream: stop_in[i]==0, or flow control disabled).
interface noc_relay_station_array_if #(
  parameter int NumPorts = noc_relay_station_array_pkg::DefaultNumPorts,
  parameter int Width    = noc_relay_station_array_pkg::DefaultWidth,
  parameter int Depth    = noc_relay_station_array_pkg::DefaultRelayDepth
);
  import noc_relay_station_array_pkg::*;

  localparam int CntW = cnt_width(Depth);

  logic [NumPorts-1:0][Width-1:0] data_in;
  logic [NumPorts-1:0]            data_void_in;
  logic [NumPorts-1:0]            stop_out;
  logic [NumPorts-1:0][Width-1:0] data_out;
  logic [NumPorts-1:0]            data_void_out;
  logic [NumPorts-1:0]            stop_in;
  logic [NumPorts-1:0][CntW-1:0]  occupancy;
  logic [NumPorts-1:0]            overflow;
  logic [NumPorts-1:0]            overflow_clr;

  // Environment side: drives flits and downstream stop, observes the station.
  modport master (
    output data_in, data_void_in, stop_in, overflow_clr,
    input  stop_out, data_out, data_void_out, occupancy, overflow
  );

  // Relay station side.
  modport slave (
    input  data_in, data_void_in, stop_in, overflow_clr,
    output stop_out, data_out, data_void_out, occupancy, overflow
  );

endinterface

// File: rtl/noc_relay_station_array_fifo.sv
// One relay channel: Depth-entry FIFO with early stop and sticky drop flag.
module noc_relay_fifo
  import noc_relay_station_array_pkg::*;
#(
  parameter bit FlowControl = 1'b1,
  parameter int Width       = DefaultWidth,
  parameter int Depth       = DefaultRelayDepth,
  parameter int StopLatency = DefaultStopLatency,
  localparam int CntW       = cnt_width(Depth)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Width-1:0] data_in,
  input  logic             data_void_in,
  output logic             stop_out,
  output logic [Width-1:0] data_out,
  output logic             data_void_out,
  input  logic             stop_in,
  output logic [CntW-1:0]  occupancy,
  output logic             overflow,
  input  logic             overflow_clr
);

  localparam int              PtrW    = ptr_width(Depth);
  localparam logic [CntW-1:0] DepthC  = CntW'(Depth);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_next;
  logic             stop_q, overflow_q;
  logic             empty, full, rd, wr, drop, stop_next;

  // Transfer decisions: a full FIFO still accepts when its head leaves this cycle.
  always_comb begin
    empty      = (count_q == '0);
    full       = (count_q == DepthC);
    rd         = !empty && (!stop_in || (FlowControl == 1'b0));
    wr         = !data_void_in && (!full || rd);
    drop       = !data_void_in && !wr;
    count_next = count_q + CntW'(wr) - CntW'(rd);
    // Stop early enough that StopLatency in-flight flits still find a free slot.
    stop_next  = (FlowControl == 1'b1) && ((Depth - int'(count_next)) <= StopLatency);
  end

  // Flit storage; cleared on reset so the idle head reads as zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < Depth; k++) mem_q[k] <= '0;
    end else if (wr) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  // Pointers, occupancy, registered stop and sticky overflow (set beats clear).
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      stop_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (wr) wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
      if (rd) rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
      count_q <= count_next;
      stop_q  <= stop_next;
      if (drop)              overflow_q <= 1'b1;
      else if (overflow_clr) overflow_q <= 1'b0;
    end
  end

  // Head of FIFO straight from storage; no bypass path from data_in.
  always_comb begin
    data_out      = mem_q[rd_ptr_q];
    data_void_out = empty;
    occupancy     = count_q;
    stop_out      = stop_q;
    overflow      = overflow_q;
  end

endmodule

// File: rtl/noc_relay_station_array.sv
// Multi-port relay station: NumPorts independent retiming FIFOs on a void/stop link.
module noc_relay_station_array
  import noc_relay_station_array_pkg::*;
#(
  parameter bit FlowControl = 1'b1,
  parameter int Width       = DefaultWidth,
  parameter int NumPorts    = DefaultNumPorts,
  parameter int Depth       = DefaultRelayDepth,
  parameter int StopLatency = DefaultStopLatency
) (
  input  logic                         clk,
  input  logic                         rst,
  noc_relay_station_array_if.slave     link
);

  // Reject configurations that cannot absorb the upstream reaction time.
  if (Depth < StopLatency + 1) begin : g_err_depth
    $error("noc_relay_station_array: Depth must be at least StopLatency+1");
  end
  if (!is_pow2(Depth)) begin : g_err_pow2
    $error("noc_relay_station_array: Depth must be a power of two");
  end
  if (NumPorts < 1) begin : g_err_ports
    $error("noc_relay_station_array: NumPorts must be at least 1");
  end

  // One fully independent FIFO per channel.
  for (genvar i = 0; i < NumPorts; i++) begin : g_ch
    noc_relay_fifo #(
      .FlowControl (FlowControl),
      .Width       (Width),
      .Depth       (Depth),
      .StopLatency (StopLatency)
    ) u_fifo (
      .clk           (clk),
      .rst           (rst),
      .data_in       (link.data_in[i]),
      .data_void_in  (link.data_void_in[i]),
      .stop_out      (link.stop_out[i]),
      .data_out      (link.data_out[i]),
      .data_void_out (link.data_void_out[i]),
      .stop_in       (link.stop_in[i]),
      .occupancy     (link.occupancy[i]),
      .overflow      (link.overflow[i]),
      .overflow_clr  (link.overflow_clr[i])
    );
  end

endmodule

// File: tb/tb_noc_relay_station_array.sv
// Bench for noc_relay_station_array: flow-controlled and non-flow-controlled
// instances share stimulus; a queue-based model checks every output each cycle.
module tb_noc_relay_station_array;
  import noc_relay_station_array_pkg::*;

  localparam int NP = 5;
  localparam int W  = 66;
  localparam int D  = 4;
  localparam int SL = 1;
  localparam int CW = $clog2(D + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  noc_relay_station_array_if #(.NumPorts(NP), .Width(W), .Depth(D)) bus_fc ();
  noc_relay_station_array_if #(.NumPorts(NP), .Width(W), .Depth(D)) bus_nf ();

  noc_relay_station_array #(
    .FlowControl(1'b1), .Width(W), .NumPorts(NP), .Depth(D), .StopLatency(SL)
  ) dut_fc (.clk(clk), .rst(rst), .link(bus_fc.slave));

  noc_relay_station_array #(
    .FlowControl(1'b0), .Width(W), .NumPorts(NP), .Depth(D), .StopLatency(SL)
  ) dut_nf (.clk(clk), .rst(rst), .link(bus_nf.slave));

  // Shared stimulus
  logic [NP-1:0][W-1:0] din;
  logic [NP-1:0]        vin, sin, clr;

  assign bus_fc.data_in      = din;
  assign bus_fc.data_void_in = vin;
  assign bus_fc.stop_in      = sin;
  assign bus_fc.overflow_clr = clr;
  assign bus_nf.data_in      = din;
  assign bus_nf.data_void_in = vin;
  assign bus_nf.stop_in      = sin;
  assign bus_nf.overflow_clr = clr;

  // Observed outputs: index 0 = flow-controlled, 1 = no flow control
  logic [NP-1:0][W-1:0]  dout [2];
  logic [NP-1:0]         vout [2];
  logic [NP-1:0]         sout [2];
  logic [NP-1:0]         ovf  [2];
  logic [NP-1:0][CW-1:0] occ  [2];

  assign dout[0] = bus_fc.data_out;
  assign vout[0] = bus_fc.data_void_out;
  assign sout[0] = bus_fc.stop_out;
  assign ovf[0]  = bus_fc.overflow;
  assign occ[0]  = bus_fc.occupancy;
  assign dout[1] = bus_nf.data_out;
  assign vout[1] = bus_nf.data_void_out;
  assign sout[1] = bus_nf.stop_out;
  assign ovf[1]  = bus_nf.overflow;
  assign occ[1]  = bus_nf.occupancy;

  // ---------------- scoreboard / reference model ----------------
  logic [W-1:0] exp_q [2*NP][$];
  bit           ov_m   [2*NP];
  bit           stop_m [2*NP];
  int           n_pass  = 0;
  int           n_total = 0;

  task automatic check(input string name, input int ch, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s ch%0d: got %0h expected %0h at %0t", name, ch, act, exp, $time);
  endtask

  // Queue model: one pop if the head is taken, one push if there is room
  // (or room is being made), otherwise the flit is lost and the flag sets.
  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < NP; i++) begin
        int k;
        int sz;
        bit rd;
        bit wr;
        k = d * NP + i;
        if (!rst) begin
          exp_q[k].delete();
          ov_m[k]   = 1'b0;
          stop_m[k] = 1'b0;
        end else begin
          sz = exp_q[k].size();
          rd = (sz > 0) && (!sin[i] || d == 1);
          wr = !vin[i] && ((sz < D) || rd);
          if (rd) void'(exp_q[k].pop_front());
          if (wr) exp_q[k].push_back(din[i]);
          if (!vin[i] && !wr) ov_m[k] = 1'b1;
          else if (clr[i])    ov_m[k] = 1'b0;
          stop_m[k] = (d == 0) && ((D - exp_q[k].size()) <= SL);
        end
      end
    end
  endtask

  task automatic check_model();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < NP; i++) begin
        int k;
        int sz;
        k  = d * NP + i;
        sz = exp_q[k].size();
        check("m_void", k, W'(vout[d][i]), W'(sz == 0));
        if (sz > 0) check("m_data", k, dout[d][i], exp_q[k][0]);
        check("m_occ",  k, W'(occ[d][i]),  W'(sz));
        check("m_stop", k, W'(sout[d][i]), W'(stop_m[k]));
        check("m_ovf",  k, W'(ovf[d][i]),  W'(ov_m[k]));
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  task automatic idle_inputs();
    din = '0;
    vin = '1;
    sin = '0;
    clr = '0;
  endtask

  function automatic logic [W-1:0] rand_flit();
    logic [W-1:0] f;
    f[31:0]  = $urandom;
    f[63:32] = $urandom;
    f[65:64] = 2'($urandom_range(3, 0));
    return f;
  endfunction

  typedef struct {
    bit           v_in;
    logic [W-1:0] d_in;
    bit           s_in;
    bit           e_void;
    logic [W-1:0] e_data;
    bit           e_stop;
    int           e_occ;
  } vec_t;

  vec_t t3 [9];

  // ---------------- test sequence ----------------
  initial begin
    idle_inputs();
    rst = 1'b0;
    repeat (2) cycle();
    rst = 1'b1;

    // 1: idle after reset
    for (int c = 0; c < 10; c++) begin
      cycle();
      check("t1_void", 0, W'(vout[0]), W'({NP{1'b1}}));
      check("t1_stop", 0, W'(sout[0]), '0);
      check("t1_occ0", 0, W'(occ[0][0]), '0);
    end
    check("t1_data0", 0, dout[0][0], '0);

    // 2: ch0 streaming, one-cycle latency
    for (int k = 0; k < 8; k++) begin
      vin[0] = 1'b0;
      din[0] = W'(32'hA0 + k);
      cycle();
      check("t2_data", 0, dout[0][0], W'(32'hA0 + k));
      check("t2_occ",  0, W'(occ[0][0]), W'(1));
      check("t2_stop", 0, W'(sout[0][0]), '0);
    end
    idle_inputs();
    cycle();

    // 3: ch1 backpressure with an upstream reacting one cycle late
    t3[0] = '{1'b0, W'(32'hB0), 1'b1, 1'b0, W'(32'hB0), 1'b0, 1};
    t3[1] = '{1'b0, W'(32'hB1), 1'b1, 1'b0, W'(32'hB0), 1'b0, 2};
    t3[2] = '{1'b0, W'(32'hB2), 1'b1, 1'b0, W'(32'hB0), 1'b1, 3};
    t3[3] = '{1'b0, W'(32'hB3), 1'b1, 1'b0, W'(32'hB0), 1'b1, 4};
    t3[4] = '{1'b1, W'(0),      1'b1, 1'b0, W'(32'hB0), 1'b1, 4};
    t3[5] = '{1'b1, W'(0),      1'b0, 1'b0, W'(32'hB1), 1'b1, 3};
    t3[6] = '{1'b1, W'(0),      1'b0, 1'b0, W'(32'hB2), 1'b0, 2};
    t3[7] = '{1'b1, W'(0),      1'b0, 1'b0, W'(32'hB3), 1'b0, 1};
    t3[8] = '{1'b1, W'(0),      1'b0, 1'b1, W'(0),      1'b0, 0};
    for (int r = 0; r < 9; r++) begin
      idle_inputs();
      vin[1] = t3[r].v_in;
      din[1] = t3[r].d_in;
      sin[1] = t3[r].s_in;
      cycle();
      check("t3_void", 1, W'(vout[0][1]), W'(t3[r].e_void));
      if (!t3[r].e_void) check("t3_data", 1, dout[0][1], t3[r].e_data);
      check("t3_stop", 1, W'(sout[0][1]), W'(t3[r].e_stop));
      check("t3_occ",  1, W'(occ[0][1]),  W'(t3[r].e_occ));
      check("t3_ovf",  1, W'(ovf[0][1]),  '0);
    end
    idle_inputs();

    // 4: ch2 non-conforming source overflows; clear, set-wins, drain
    sin[2] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      vin[2] = 1'b0;
      din[2] = W'(32'hC0 + k);
      cycle();
      check("t4_occ", 2, W'(occ[0][2]), W'((k < 4) ? k + 1 : 4));
      check("t4_ovf", 2, W'(ovf[0][2]), W'(k == 4));
    end
    vin[2] = 1'b1; clr[2] = 1'b1;
    cycle();
    check("t4_clr", 2, W'(ovf[0][2]), '0);
    clr[2] = 1'b0; vin[2] = 1'b0; din[2] = W'(32'hC5);
    cycle();
    check("t4_reset", 2, W'(ovf[0][2]), W'(1));
    clr[2] = 1'b1; din[2] = W'(32'hC6);
    cycle();
    check("t4_setwins", 2, W'(ovf[0][2]), W'(1));
    vin[2] = 1'b1;
    cycle();
    check("t4_clr2", 2, W'(ovf[0][2]), '0);
    check("t4_head", 2, dout[0][2], W'(32'hC0));
    clr[2] = 1'b0; sin[2] = 1'b0;
    for (int k = 1; k < 4; k++) begin
      cycle();
      check("t4_drain", 2, dout[0][2], W'(32'hC0 + k));
    end
    cycle();
    check("t4_empty", 2, W'(vout[0][2]), W'(1));

    // 5: full ch3 with simultaneous read and write
    sin[3] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      vin[3] = 1'b0;
      din[3] = W'(32'hD0 + k);
      cycle();
    end
    check("t5_full", 3, W'(occ[0][3]), W'(4));
    check("t5_stop", 3, W'(sout[0][3]), W'(1));
    sin[3] = 1'b0; din[3] = W'(32'hD4);
    cycle();
    check("t5_occ",  3, W'(occ[0][3]), W'(4));
    check("t5_head", 3, dout[0][3], W'(32'hD1));
    check("t5_ovf",  3, W'(ovf[0][3]), '0);
    vin[3] = 1'b1;
    for (int k = 2; k < 5; k++) begin
      cycle();
      check("t5_order", 3, dout[0][3], W'(32'hD0 + k));
    end
    cycle();

    // 6: reset while ch4 holds three flits
    idle_inputs();
    sin[4] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      vin[4] = 1'b0;
      din[4] = W'(32'hE0 + k);
      cycle();
    end
    check("t6_pre", 4, W'(occ[0][4]), W'(3));
    idle_inputs();
    rst = 1'b0;
    cycle();
    check("t6_void", 4, W'(vout[0][4]), W'(1));
    check("t6_occ",  4, W'(occ[0][4]),  '0);
    rst = 1'b1;
    cycle();
    check("t6_void2", 4, W'(vout[0][4]), W'(1));
    vin[4] = 1'b0; din[4] = W'(32'hF0);
    cycle();
    check("t6_first", 4, dout[0][4], W'(32'hF0));
    idle_inputs();
    cycle();

    // Random traffic, mostly conforming upstream, occasional resets
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NP; i++) begin
        if (sout[0][i] && $urandom_range(0, 9) != 0) vin[i] = 1'b1;
        else vin[i] = ($urandom_range(0, 3) == 0);
        din[i] = rand_flit();
        sin[i] = ($urandom_range(0, 2) == 0);
        clr[i] = ($urandom_range(0, 15) == 0);
      end
      rst = ($urandom_range(0, 199) != 0);
      cycle();
    end
    rst = 1'b1;
    idle_inputs();
    repeat (6) cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
